// File: rtl/des_iter_ctrl.sv
// Sequencing controller for an iterative DES datapath: load, 16 rounds, final
// permutation capture and a valid/ready hold of the result.
module des_iter_ctrl #(
  parameter bit BACK2BACK = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_decrypt,
  input  logic       i_abort,
  input  logic       i_out_ready,
  output logic       o_busy,
  output logic       o_ld_data,
  output logic       o_key_ld,
  output logic       o_rnd_en,
  output logic [3:0] o_round,
  output logic [1:0] o_key_shift,
  output logic       o_key_dir,
  output logic       o_last_round,
  output logic       o_cap_out,
  output logic       o_out_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_mode;
  logic       r_busy;
  logic       r_ld_data;
  logic       r_key_ld;
  logic       r_rnd_en;
  logic [3:0] r_round;
  logic [1:0] r_key_shift;
  logic       r_key_dir;
  logic       r_last_round;
  logic       r_cap_out;
  logic       r_out_valid;

  logic       w_b2b_restart;

  // Decrypt round 0 uses no rotation: right-rotating walks the key schedule backwards.
  function automatic logic [1:0] f_shift(input logic [3:0] rnd, input logic dec);
    if (rnd == 4'd0)
      return dec ? 2'd0 : 2'd1;
    else if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15)
      return 2'd1;
    else
      return 2'd2;
  endfunction

  assign w_b2b_restart = BACK2BACK && i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_busy       <= 1'b0;
      r_ld_data    <= 1'b0;
      r_key_ld     <= 1'b0;
      r_rnd_en     <= 1'b0;
      r_round      <= 4'd0;
      r_key_shift  <= 2'd0;
      r_key_dir    <= 1'b0;
      r_last_round <= 1'b0;
      r_cap_out    <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      // Strobes are single-cycle; each state re-asserts what its successor needs.
      r_ld_data    <= 1'b0;
      r_key_ld     <= 1'b0;
      r_rnd_en     <= 1'b0;
      r_round      <= 4'd0;
      r_key_shift  <= 2'd0;
      r_key_dir    <= 1'b0;
      r_last_round <= 1'b0;
      r_cap_out    <= 1'b0;
      if (i_abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_mode    <= i_decrypt;
              r_state   <= S_LOAD;
              r_busy    <= 1'b1;
              r_ld_data <= 1'b1;
              r_key_ld  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_state     <= S_ROUND;
            r_rnd_en    <= 1'b1;
            r_round     <= 4'd0;
            r_key_shift <= f_shift(4'd0, r_mode);
            r_key_dir   <= r_mode;
          end
          S_ROUND: begin
            if (r_round == 4'd15) begin
              r_state   <= S_FINAL;
              r_cap_out <= 1'b1;
            end else begin
              r_rnd_en     <= 1'b1;
              r_round      <= r_round + 4'd1;
              r_key_shift  <= f_shift(r_round + 4'd1, r_mode);
              r_key_dir    <= r_mode;
              r_last_round <= (r_round == 4'd14);
            end
          end
          S_FINAL: begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end
          S_HOLD: begin
            if (i_out_ready) begin
              r_out_valid <= 1'b0;
              if (w_b2b_restart) begin
                r_mode    <= i_decrypt;
                r_state   <= S_LOAD;
                r_ld_data <= 1'b1;
                r_key_ld  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_ld_data    = r_ld_data;
  assign o_key_ld     = r_key_ld;
  assign o_rnd_en     = r_rnd_en;
  assign o_round      = r_round;
  assign o_key_shift  = r_key_shift;
  assign o_key_dir    = r_key_dir;
  assign o_last_round = r_last_round;
  assign o_cap_out    = r_cap_out;
  assign o_out_valid  = r_out_valid;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Self-checking bench for des_iter_ctrl: directed scenarios plus random traffic,
// compared every cycle against a timeline model keyed on cycles since start.
module tb_des_iter_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       decrypt;
  logic       abort;
  logic       out_ready;
  logic       busy;
  logic       ld_data;
  logic       key_ld;
  logic       rnd_en;
  logic [3:0] round;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       last_round;
  logic       cap_out;
  logic       out_valid;

  int n_tests;
  int n_fail;
  int cyc;

  // Model: an operation accepted at cycle T is in phase k = cycle - T (k >= 1).
  bit m_active;
  int m_k;
  bit m_mode;

  int ks_tbl [2][16] = '{
    '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1},
    '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1}
  };

  des_iter_ctrl #(.BACK2BACK(1'b1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_decrypt    (decrypt),
    .i_abort      (abort),
    .i_out_ready  (out_ready),
    .o_busy       (busy),
    .o_ld_data    (ld_data),
    .o_key_ld     (key_ld),
    .o_rnd_en     (rnd_en),
    .o_round      (round),
    .o_key_shift  (key_shift),
    .o_key_dir    (key_dir),
    .o_last_round (last_round),
    .o_cap_out    (cap_out),
    .o_out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Packed as {busy, ld_data, key_ld, rnd_en, round, key_shift, key_dir, last_round, cap_out, out_valid}
  function automatic logic [13:0] f_expect();
    logic [13:0] v;
    bit in_rnd;
    int r;
    in_rnd = m_active && m_k >= 2 && m_k <= 17;
    r = in_rnd ? m_k - 2 : 0;
    v[13]    = m_active;
    v[12]    = m_active && m_k == 1;
    v[11]    = m_active && m_k == 1;
    v[10]    = in_rnd;
    v[9:6]   = 4'(r);
    v[5:4]   = in_rnd ? 2'(ks_tbl[m_mode][r]) : 2'd0;
    v[3]     = in_rnd && m_mode;
    v[2]     = m_active && m_k == 17;
    v[1]     = m_active && m_k == 18;
    v[0]     = m_active && m_k >= 19;
    return v;
  endfunction

  task automatic model_update(input bit s, input bit d, input bit a, input bit r, input bit rs);
    if (rs) begin
      m_active = 0;
      m_mode   = 0;
    end else if (a) begin
      m_active = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1;
        m_k      = 1;
        m_mode   = d;
      end
    end else if (m_k >= 19) begin
      if (r) begin
        if (s) begin
          m_k    = 1;
          m_mode = d;
        end else begin
          m_active = 0;
        end
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic step(input string tag, input bit s, input bit d, input bit a,
                      input bit r, input bit rs);
    start     = s;
    decrypt   = d;
    abort     = a;
    out_ready = r;
    rst       = rs;
    model_update(s, d, a, r, rs);
    @(negedge clk);
    cyc++;
    chk(tag, 32'({busy, ld_data, key_ld, rnd_en, round, key_shift, key_dir,
                  last_round, cap_out, out_valid}), 32'(f_expect()));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    m_active = 0;
    m_k      = 0;
    m_mode   = 0;

    step("reset", 0, 0, 0, 0, 1);
    step("reset", 1, 1, 0, 1, 1);

    step("enc_start", 1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step("enc_seq", 0, 0, 0, 1, 0);

    step("dec_start", 1, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) step("dec_seq", 0, 1'($urandom), 0, 1, 0);

    step("hold_start", 1, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step("hold_run", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("hold_wait", (i == 2), 1, 0, 0, 0);
    step("hold_release", 0, 0, 0, 1, 0);
    step("hold_idle", 0, 0, 0, 1, 0);

    step("b2b_start", 1, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step("b2b_run1", 0, 0, 0, 0, 0);
    step("b2b_hs", 1, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) step("b2b_run2", 0, 0, 0, 1, 0);

    step("abort_start", 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step("abort_run", 0, 0, 0, 1, 0);
    chk("abort_at_r7", 32'(round), 32'd7);
    step("abort", 1, 1, 1, 1, 0);
    step("after_abort", 1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step("restart_seq", 0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      step("random",
           ($urandom_range(0, 3) == 0),
           1'($urandom),
           ($urandom_range(0, 63) == 0),
           1'($urandom),
           ($urandom_range(0, 255) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
